decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
Registered register-decode stage for the RV32I pipeline.
- Extracts rs1/rs2/rd from the instruction and decides, per opcode, which sources are read and whether rd is written.
- Tracks in-flight register writes in a per-register pending-count scoreboard.
- Stalls issue on RAW hazards and on counter saturation.
- Sits between fetch and execute, with valid/ready on both sides and a writeback port that retires pending writes.

Parameters:
PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^PEND_W-1.
X0_HARDWIRED, 1, 1: rd=0 never writes and x0 is never tracked or hazarded. 0: x0 is treated like any other register.
WB_BYPASS, 0, 1: a same-cycle writeback that drives a hazarding register's count to 0 clears the hazard in that cycle. 0: the hazard clears the cycle after the writeback.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  instruction valid from fetch
in_ready  out  1  stage accepts instruction this cycle
inst  in  32  instruction word
out_valid  out  1  decoded instruction valid to execute
out_ready  in  1  execute accepts decoded instruction
out_rs1  out  5  registered inst[19:15]
out_rs2  out  5  registered inst[24:20]
out_rd  out  5  registered inst[11:7]
out_uses_rs1  out  1  instruction reads rs1
out_uses_rs2  out  1  instruction reads rs2
out_reg_wr_en  out  1  instruction writes rd
wb_valid  in  1  writeback retiring one register write
wb_rd  in  5  register being retired
hazard  out  1  combinational: current in_valid instruction blocked by scoreboard
pending_any  out  1  registered: any counter non-zero
wb_err  out  1  sticky: writeback to a register with count 0

Behaviour:
- Opcode decode (combinational, on inst[6:0]):
  - uses_rs1 for 3, 19, 35, 51, 99, 103.
  - uses_rs2 for 35, 51, 99.
  - wr_en for 3, 19, 23, 51, 55, 103, 111.
  - Any other opcode: all three 0; the instruction still flows through as a bubble-like op.
  - When X0_HARDWIRED=1, wr_en is also forced 0 if rd=0, and rs=0 never hazards.
- hazard = in_valid AND any of:
  - uses_rs1 and cnt[rs1]!=0
  - uses_rs2 and cnt[rs2]!=0
  - wr_en and cnt[rd]==all-ones (saturation)
  - WB_BYPASS=1: a term is suppressed when wb_valid, wb_rd matches that register, and its cnt==1. The saturation term is likewise relieved by a same-register writeback.
- in_ready = (!out_valid OR out_ready) AND !hazard. in_ready does not depend on in_valid except through hazard.
- Accept (in_valid AND in_ready): the output register loads all decoded fields and out_valid=1 at the next edge. Latency is 1 cycle.
- out_valid AND out_ready AND no accept: out_valid drops to 0.
- While out_valid=1 and out_ready=0, all out_* fields hold stable.
- Scoreboard update per edge, with inc = accept AND wr_en and dec = wb_valid AND cnt[wb_rd]!=0:
  - inc only: cnt[rd]+1.
  - dec only: cnt[wb_rd]-1.
  - inc and dec on the same register in the same cycle: count unchanged.
  - inc and dec on different registers: both apply.
- wb_valid to a register with count 0: no change, wb_err set. wb_err clears only on rst.
- X0_HARDWIRED=1: cnt[0] stays 0; wb_rd=0 is ignored and never sets wb_err.
- pending_any = registered OR of next-state counters.
- Reset (rst=1 at edge):
  - All counters 0; out_valid, out_rs1/rs2/rd, out_uses_rs1/rs2, out_reg_wr_en, pending_any and wb_err all 0.
  - An in-flight output or scoreboard entry is discarded; the writeback side must be flushed in the same reset.
  - in_ready and hazard follow combinationally from the reset state: in_ready=1 while rst is low after reset, and hazard=0.

Test Plan:
1. Reset, then inst=0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, out_rd=1, out_reg_wr_en=1, out_uses_rs1=1, out_uses_rs2=0; cnt[1]=1, pending_any=1.
2. RAW: after test 1, inst=0x00108133 (add x2,x1,x1) → hazard=1, in_ready=0. Pulse wb_valid with wb_rd=1:
   - WB_BYPASS=0: accepted the following cycle.
   - WB_BYPASS=1: accepted in the same cycle.
3. Saturation: PEND_W=2, issue three writes to x5 with no writeback → fourth write to x5 stalls with hazard=1. Writeback x5 in the stall cycle with WB_BYPASS=1 → fourth write accepted and cnt[5] stays 3.
4. Backpressure: out_ready=0 with out_valid=1 → in_ready=0 and outputs hold for 5 cycles. Then out_ready=1 with new in_valid → back-to-back accepts, one per cycle.
5. Edge cases:
   - inst=0x00000013 (addi x0,x0,0), X0_HARDWIRED=1 → out_reg_wr_en=0, cnt unchanged.
   - Store 0x00112023 → uses_rs1=1, uses_rs2=1, wr_en=0.
   - wb_valid to x7 with cnt 0 → wb_err=1, sticky until rst.
6. Reset mid-operation: counters non-zero and out_valid=1, assert rst for 1 cycle → all outputs 0, pending_any=0, and the next addi is accepted without hazard.

Source files
------------

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: registered RV32I register-decode stage with a per-register
// pending-write scoreboard. It stalls issue on RAW hazards and on pending-counter
// saturation, and retires pending writes through the writeback port.
module decode_scoreboard #(
  parameter int PEND_W       = 2,
  parameter bit X0_HARDWIRED = 1'b1,
  parameter bit WB_BYPASS    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_uses_rs1,
  output logic        out_uses_rs2,
  output logic        out_reg_wr_en,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        hazard,
  output logic        pending_any,
  output logic        wb_err
);

  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  // A counter at all-ones cannot take another in-flight write.
  function automatic logic cnt_saturated(input logic [PEND_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  logic [PEND_W-1:0] cnt     [32];
  logic [PEND_W-1:0] cnt_nxt [32];

  logic [6:0] dec_opc;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       dec_wr_en;

  logic [PEND_W-1:0] cnt_rs1;
  logic [PEND_W-1:0] cnt_rs2;
  logic [PEND_W-1:0] cnt_rd;
  logic [PEND_W-1:0] cnt_wb;

  logic wb_live;
  logic haz_rs1;
  logic haz_rs2;
  logic haz_sat;
  logic accept;
  logic inc;
  logic dec;
  logic wb_bad;
  logic inc_i;
  logic dec_i;
  logic any_nxt;

  logic       vld_p1;
  logic [4:0] rs1_p1;
  logic [4:0] rs2_p1;
  logic [4:0] rd_p1;
  logic       uses_rs1_p1;
  logic       uses_rs2_p1;
  logic       wr_en_p1;

  // funct3/funct7/immediate bits play no part in register decode
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[31:25], inst[14:12]};

  assign dec_opc = inst[6:0];
  assign dec_rs1 = inst[19:15];
  assign dec_rs2 = inst[24:20];
  assign dec_rd  = inst[11:7];

  // Opcode decode: which sources are read and whether rd is written
  always_comb begin
    dec_uses_rs1 = 1'b0;
    dec_uses_rs2 = 1'b0;
    dec_wr_en    = 1'b0;
    case (dec_opc)
      7'd3:   begin dec_uses_rs1 = 1'b1; dec_wr_en = 1'b1; end
      7'd19:  begin dec_uses_rs1 = 1'b1; dec_wr_en = 1'b1; end
      7'd23:  dec_wr_en = 1'b1;
      7'd35:  begin dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1; end
      7'd51:  begin dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1; dec_wr_en = 1'b1; end
      7'd55:  dec_wr_en = 1'b1;
      7'd99:  begin dec_uses_rs1 = 1'b1; dec_uses_rs2 = 1'b1; end
      7'd103: begin dec_uses_rs1 = 1'b1; dec_wr_en = 1'b1; end
      7'd111: dec_wr_en = 1'b1;
      default: ;
    endcase
    if (X0_HARDWIRED && (dec_rd == 5'd0)) dec_wr_en = 1'b0;
  end

  assign cnt_rs1 = cnt[dec_rs1];
  assign cnt_rs2 = cnt[dec_rs2];
  assign cnt_rd  = cnt[dec_rd];
  assign cnt_wb  = cnt[wb_rd];

  // x0 writebacks are meaningless when x0 is hardwired, so drop them entirely
  assign wb_live = wb_valid && !(X0_HARDWIRED && (wb_rd == 5'd0));

  // Hazard terms; with bypass, a writeback that empties the counter this cycle
  // (or frees a saturated slot) releases the instruction immediately
  always_comb begin
    haz_rs1 = dec_uses_rs1 && !(X0_HARDWIRED && (dec_rs1 == 5'd0)) && (cnt_rs1 != '0)
              && !(WB_BYPASS && wb_live && (wb_rd == dec_rs1) && (cnt_rs1 == CNT_ONE));
    haz_rs2 = dec_uses_rs2 && !(X0_HARDWIRED && (dec_rs2 == 5'd0)) && (cnt_rs2 != '0)
              && !(WB_BYPASS && wb_live && (wb_rd == dec_rs2) && (cnt_rs2 == CNT_ONE));
    haz_sat = dec_wr_en && cnt_saturated(cnt_rd)
              && !(WB_BYPASS && wb_live && (wb_rd == dec_rd));
  end

  assign hazard   = in_valid && (haz_rs1 || haz_rs2 || haz_sat);
  assign in_ready = (!vld_p1 || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign inc      = accept && dec_wr_en;
  assign dec      = wb_live && (cnt_wb != '0);
  assign wb_bad   = wb_live && (cnt_wb == '0);

  // Next-state counters: an issue and a retire on the same register cancel
  always_comb begin
    any_nxt = 1'b0;
    inc_i   = 1'b0;
    dec_i   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      inc_i      = inc && (dec_rd == 5'(i));
      dec_i      = dec && (wb_rd == 5'(i));
      cnt_nxt[i] = cnt[i];
      if (inc_i && !dec_i)      cnt_nxt[i] = cnt[i] + CNT_ONE;
      else if (dec_i && !inc_i) cnt_nxt[i] = cnt[i] - CNT_ONE;
      if (X0_HARDWIRED && (i == 0)) cnt_nxt[i] = '0;
      any_nxt = any_nxt || (cnt_nxt[i] != '0);
    end
  end

  // Scoreboard state, pending summary and sticky writeback error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      pending_any <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
      pending_any <= any_nxt;
      if (wb_bad) wb_err <= 1'b1;
    end
  end

  // ---- stage p1: decoded instruction register toward execute ----
  // Loads on accept, drains when execute takes it, holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rs1_p1      <= 5'd0;
      rs2_p1      <= 5'd0;
      rd_p1       <= 5'd0;
      uses_rs1_p1 <= 1'b0;
      uses_rs2_p1 <= 1'b0;
      wr_en_p1    <= 1'b0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      rs1_p1      <= dec_rs1;
      rs2_p1      <= dec_rs2;
      rd_p1       <= dec_rd;
      uses_rs1_p1 <= dec_uses_rs1;
      uses_rs2_p1 <= dec_uses_rs2;
      wr_en_p1    <= dec_wr_en;
    end else if (out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign out_rs1       = rs1_p1;
  assign out_rs2       = rs2_p1;
  assign out_rd        = rd_p1;
  assign out_uses_rs1  = uses_rs1_p1;
  assign out_uses_rs2  = uses_rs2_p1;
  assign out_reg_wr_en = wr_en_p1;

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed bench for decode_scoreboard. One instance uses
// the default configuration (no writeback bypass), a second enables bypass.
module tb_decode_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst;
  logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;
  logic        out_uses_rs1, out_uses_rs2, out_reg_wr_en;
  logic        wb_valid, hazard, pending_any, wb_err;

  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_inst;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd, b_wb_rd;
  logic        b_out_uses_rs1, b_out_uses_rs2, b_out_reg_wr_en;
  logic        b_wb_valid, b_hazard, b_pending_any, b_wb_err;

  decode_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_reg_wr_en(out_reg_wr_en), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .hazard(hazard), .pending_any(pending_any), .wb_err(wb_err)
  );

  decode_scoreboard #(.PEND_W(2), .X0_HARDWIRED(1'b1), .WB_BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .inst(b_inst),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_rd(b_out_rd), .out_uses_rs1(b_out_uses_rs1), .out_uses_rs2(b_out_uses_rs2),
    .out_reg_wr_en(b_out_reg_wr_en), .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
    .hazard(b_hazard), .pending_any(b_pending_any), .wb_err(b_wb_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = 32'h0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_inst = 32'h0; b_out_ready = 1'b1;
    b_wb_valid = 1'b0; b_wb_rd = 5'd0;
    repeat (2) tick();
    rst = 1'b0; b_rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_rd", 32'(out_rd), 0);
    check("rst_wr_en", 32'(out_reg_wr_en), 0);
    check("rst_pending", 32'(pending_any), 0);
    check("rst_wb_err", 32'(wb_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_hazard", 32'(hazard), 0);

    // addi x1,x0,5
    in_valid = 1'b1; inst = 32'h00500093; #1;
    check("t1_in_ready", 32'(in_ready), 1);
    tick();
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_rd", 32'(out_rd), 1);
    check("t1_out_rs1", 32'(out_rs1), 0);
    check("t1_wr_en", 32'(out_reg_wr_en), 1);
    check("t1_uses_rs1", 32'(out_uses_rs1), 1);
    check("t1_uses_rs2", 32'(out_uses_rs2), 0);
    check("t1_pending", 32'(pending_any), 1);
    check("t1_cnt1", 32'(dut.cnt[1]), 1);

    // add x2,x1,x1 blocked on x1; writeback without bypass releases it next cycle
    inst = 32'h00108133; #1;
    check("t2_hazard", 32'(hazard), 1);
    check("t2_in_ready", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    check("t2_hazard_wb_cycle", 32'(hazard), 1);
    tick();
    wb_valid = 1'b0; #1;
    check("t2_out_drained", 32'(out_valid), 0);
    check("t2_hazard_clear", 32'(hazard), 0);
    check("t2_in_ready_clear", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t2_out_valid", 32'(out_valid), 1);
    check("t2_out_rd", 32'(out_rd), 2);
    check("t2_out_rs1", 32'(out_rs1), 1);
    check("t2_out_rs2", 32'(out_rs2), 1);
    check("t2_uses_rs2", 32'(out_uses_rs2), 1);
    wb_valid = 1'b1; wb_rd = 5'd2;
    tick();
    wb_valid = 1'b0;
    check("t2_pending_clear", 32'(pending_any), 0);

    // three writes to x5 fill its counter; the fourth stalls
    in_valid = 1'b1; inst = 32'h00100293;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_fill_ready", 32'(in_ready), 1);
      tick();
    end
    #1;
    check("t3_cnt5_full", 32'(dut.cnt[5]), 3);
    check("t3_sat_hazard", 32'(hazard), 1);
    check("t3_sat_ready", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    check("t3_sat_hazard_wb", 32'(hazard), 1);
    tick();
    wb_valid = 1'b0; #1;
    check("t3_cnt5_after_wb", 32'(dut.cnt[5]), 2);
    check("t3_hazard_clear", 32'(hazard), 0);
    tick();
    in_valid = 1'b0;
    check("t3_cnt5_refill", 32'(dut.cnt[5]), 3);
    check("t3_out_rd", 32'(out_rd), 5);
    wb_valid = 1'b1; wb_rd = 5'd5;
    repeat (3) tick();
    wb_valid = 1'b0;
    check("t3_pending_clear", 32'(pending_any), 0);
    check("t3_wb_err", 32'(wb_err), 0);

    // backpressure: output holds, then back-to-back accepts
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00100193; #1;
    check("t4_first_ready", 32'(in_ready), 1);
    tick();
    inst = 32'h00100213;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_hold_ready", 32'(in_ready), 0);
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_rd", 32'(out_rd), 3);
      tick();
    end
    out_ready = 1'b1; #1;
    check("t4_release_ready", 32'(in_ready), 1);
    tick();
    check("t4_b2b_rd4", 32'(out_rd), 4);
    inst = 32'h00100313; #1;
    check("t4_b2b_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t4_b2b_rd6", 32'(out_rd), 6);
    check("t4_b2b_valid", 32'(out_valid), 1);
    wb_valid = 1'b1; wb_rd = 5'd3; tick();
    wb_rd = 5'd4; tick();
    wb_rd = 5'd6; tick();
    wb_valid = 1'b0;
    check("t4_pending_clear", 32'(pending_any), 0);

    // edge cases: nop to x0, store, writeback errors
    in_valid = 1'b1; inst = 32'h00000013;
    tick();
    in_valid = 1'b0;
    check("t5_nop_valid", 32'(out_valid), 1);
    check("t5_nop_wr_en", 32'(out_reg_wr_en), 0);
    check("t5_nop_pending", 32'(pending_any), 0);
    in_valid = 1'b1; inst = 32'h00112023; #1;
    check("t5_store_hazard", 32'(hazard), 0);
    tick();
    in_valid = 1'b0;
    check("t5_store_uses_rs1", 32'(out_uses_rs1), 1);
    check("t5_store_uses_rs2", 32'(out_uses_rs2), 1);
    check("t5_store_wr_en", 32'(out_reg_wr_en), 0);
    check("t5_store_rs1", 32'(out_rs1), 2);
    check("t5_store_rs2", 32'(out_rs2), 1);
    check("t5_store_pending", 32'(pending_any), 0);
    wb_valid = 1'b1; wb_rd = 5'd0;
    tick();
    check("t5_wb_x0_ignored", 32'(wb_err), 0);
    wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;
    check("t5_wb_err_set", 32'(wb_err), 1);
    repeat (3) tick();
    check("t5_wb_err_sticky", 32'(wb_err), 1);

    // reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500093;
    tick();
    in_valid = 1'b0;
    check("t6_pre_valid", 32'(out_valid), 1);
    check("t6_pre_pending", 32'(pending_any), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_out_rd", 32'(out_rd), 0);
    check("t6_uses_rs1", 32'(out_uses_rs1), 0);
    check("t6_wr_en", 32'(out_reg_wr_en), 0);
    check("t6_pending", 32'(pending_any), 0);
    check("t6_wb_err", 32'(wb_err), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h00108133; #1;
    check("t6_post_hazard", 32'(hazard), 0);
    check("t6_post_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t6_post_valid", 32'(out_valid), 1);
    check("t6_post_rd", 32'(out_rd), 2);

    // bypass instance: same-cycle writeback releases RAW and saturation stalls
    b_in_valid = 1'b1; b_inst = 32'h00500093;
    tick();
    b_inst = 32'h00108133; #1;
    check("b_raw_hazard", 32'(b_hazard), 1);
    b_wb_valid = 1'b1; b_wb_rd = 5'd1; #1;
    check("b_raw_bypass_hazard", 32'(b_hazard), 0);
    check("b_raw_bypass_ready", 32'(b_in_ready), 1);
    tick();
    b_wb_valid = 1'b0;
    check("b_raw_out_valid", 32'(b_out_valid), 1);
    check("b_raw_out_rd", 32'(b_out_rd), 2);
    b_inst = 32'h00100293;
    repeat (3) tick();
    #1;
    check("b_sat_hazard", 32'(b_hazard), 1);
    b_wb_valid = 1'b1; b_wb_rd = 5'd5; #1;
    check("b_sat_bypass_hazard", 32'(b_hazard), 0);
    check("b_sat_bypass_ready", 32'(b_in_ready), 1);
    tick();
    b_wb_valid = 1'b0; b_in_valid = 1'b0;
    check("b_sat_cnt5", 32'(dut_b.cnt[5]), 3);
    check("b_sat_out_rd", 32'(b_out_rd), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
